// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_sub_pkg;

    localparam int SERIAL_SUB_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: Diff = in1 - in2 - Bin, Bout is the borrow out.
module full_subtractor (
    output logic Diff,
    output logic Bout,
    input  logic in1,
    input  logic in2,
    input  logic Bin
);

    logic w_axb;

    assign w_axb = in1 ^ in2;
    assign Diff  = w_axb ^ Bin;
    assign Bout  = (~in1 & in2) | (~w_axb & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (in1 - in2 - Bin), LSB first, one full_subtractor cell.
// Optional signed-overflow output Ovf is built when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SERIAL_SUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             Bin,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow,
    output logic             busy,
    output logic             done
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    // Handshake: start is accepted only in IDLE (and not under rst); busy is high while
    // bits are being computed; done pulses for one cycle when Diff/Borrow are updated.
    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [CW-1:0]    r_cnt;
    logic             r_br;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;

    logic             w_d;
    logic             w_bout;
    logic             w_accept;
    logic             w_last;

    full_subtractor u_cell (
        .Diff (w_d),
        .Bout (w_bout),
        .in1  (r_a[0]),
        .in2  (r_b[0]),
        .Bin  (r_br)
    );

    assign w_accept = (r_state == IDLE) && start;
    assign w_last   = (r_state == RUN) && (r_cnt == LAST);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = RUN;
            RUN:     if (r_cnt == LAST) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_cnt    <= '0;
            r_br     <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a   <= in1;
                r_b   <= in2;
                r_res <= '0;
                r_cnt <= '0;
                r_br  <= Bin;
            end else if (r_state == RUN) begin
                // Result fills from the MSB end so it is aligned after WIDTH shifts.
                r_a   <= {1'b0, r_a[WIDTH-1:1]};
                r_b   <= {1'b0, r_b[WIDTH-1:1]};
                r_res <= {w_d, r_res[WIDTH-1:1]};
                r_br  <= w_bout;
                if (!w_last) begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
            if (w_last) begin
                r_diff   <= {w_d, r_res[WIDTH-1:1]};
                r_borrow <= w_bout;
            end
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic r_ovf;

    // Signed overflow: borrow into the MSB differs from borrow out of it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= r_br ^ w_bout;
        end
    end

    assign Ovf = r_ovf;
`endif

    assign Diff   = r_diff;
    assign Borrow = r_borrow;
    assign busy   = (r_state == RUN);
    assign done   = (r_state == DONE);

endmodule
